// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word at a time and serialises it as a UART frame.
// Start bit, data LSB first, optional parity, then one or two stop bits.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    baud_cnt_q, baud_cnt_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic             parity_q, parity_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic             bit_end;
  logic [WIDTH-1:0] shift_nx;

  assign fifo_rd_en = (state_q == IDLE) & ~fifo_empty & ~rst;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  assign bit_end  = (baud_cnt_q == BAUD_LAST);
  assign shift_nx = shift_q >> 1;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    stop_cnt_d   = stop_cnt_q;
    parity_d     = parity_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    baud_cnt_d   = bit_end ? '0 : baud_cnt_q + BW'(1);
    unique case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        if (!fifo_empty) begin
          state_d = FETCH;
          busy_d  = 1'b1;
        end
      end
      FETCH: begin
        // Read data arrives here, one cycle after the pop.
        shift_d    = fifo_data;
        parity_d   = (^fifo_data) ^ ODD;
        baud_cnt_d = '0;
        tx_d       = 1'b0;
        state_d    = START;
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = shift_nx;
          bit_idx_d = bit_idx_q + IW'(1);
          tx_d      = shift_nx[0];
          if (bit_idx_q == IDX_LAST) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d    = STOP;
              stop_cnt_d = 1'b0;
              tx_d       = 1'b1;
            end
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      baud_cnt_q   <= '0;
      bit_idx_q    <= '0;
      stop_cnt_q   <= 1'b0;
      parity_q     <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      stop_cnt_q   <= stop_cnt_d;
      parity_q     <= parity_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: four instances cover plain, even/odd
// parity and two-stop-bit frames, each fed by a small FIFO model.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int N   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       empty [N];
  logic [7:0] data  [N];
  logic       rd    [N];
  logic       tx    [N];
  logic       busy  [N];
  logic       fd    [N];

  bit [7:0] mem [N][8];
  int       wp  [N];
  int       rp  [N];
  int       fdc [N];
  int       cyc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign empty[g] = (wp[g] == rp[g]);
    fifo_uart_tx #(
      .WIDTH       (8),
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   ((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD  ((g == 2) ? 1 : 0),
      .STOP_BITS   ((g == 3) ? 2 : 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .fifo_empty(empty[g]),
      .fifo_data (data[g]),
      .fifo_rd_en(rd[g]),
      .tx        (tx[g]),
      .busy      (busy[g]),
      .frame_done(fd[g])
    );
  end

  // FIFO model: read data valid the cycle after the pop.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < N; g++) begin
      if (rd[g]) begin
        data[g] <= mem[g][rp[g] % 8];
        rp[g]   <= rp[g] + 1;
      end
      if (fd[g]) fdc[g] <= fdc[g] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int g, input bit [7:0] v);
    mem[g][wp[g] % 8] = v;
    wp[g]++;
  endtask

  // Waits (bounded) for a start bit, then records nbits bits of CPB cycles.
  task automatic rx_frame(input int g, input int nbits,
                          output logic [15:0] bits, output int t0,
                          output bit ok);
    logic v;
    bits = '0;
    ok   = 1'b1;
    t0   = 0;
    for (int i = 0; i < 300 && tx[g] !== 1'b0; i++) @(negedge clk);
    if (tx[g] !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    t0 = cyc;
    for (int b = 0; b < nbits; b++) begin
      if (b > 0) @(negedge clk);
      v = tx[g];
      for (int k = 1; k < CPB; k++) begin
        @(negedge clk);
        if (tx[g] !== v) ok = 1'b0;
      end
      bits[b] = v;
    end
  endtask

  logic [15:0] bits;
  int          t0, t1, t2, base, n, bad;
  bit          ok;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx[0], 1'b1);
    check("rst_busy", busy[0], 1'b0);
    check("rst_done", fd[0], 1'b0);
    check("rst_rd", rd[0], 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single frame 0xA5
    push(0, 8'hA5);
    #1;
    check("t1_pop", rd[0], 1'b1);
    @(negedge clk);
    check("t1_fetch_tx", tx[0], 1'b1);
    check("t1_fetch_busy", busy[0], 1'b1);
    check("t1_fetch_rd", rd[0], 1'b0);
    rx_frame(0, 10, bits, t0, ok);
    check("t1_stable", ok, 1'b1);
    check("t1_bits", bits, 16'h034A);
    @(negedge clk);
    check("t1_done", fd[0], 1'b1);
    check("t1_busy", busy[0], 1'b0);
    check("t1_len", cyc - t0, 40);
    check("t1_empty", empty[0], 1'b1);
    check("t1_pops", rp[0], 1);
    @(negedge clk);
    check("t1_done_pulse", fd[0], 1'b0);

    // 2: back-to-back
    base = fdc[0];
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    rx_frame(0, 10, bits, t0, ok);
    check("t2_ok0", ok, 1'b1);
    check("t2_w0", bits[8:1], 8'h00);
    rx_frame(0, 10, bits, t1, ok);
    check("t2_ok1", ok, 1'b1);
    check("t2_w1", bits[8:1], 8'hFF);
    check("t2_gap01", t1 - t0, 42);
    rx_frame(0, 10, bits, t2, ok);
    check("t2_ok2", ok, 1'b1);
    check("t2_w2", bits[8:1], 8'h3C);
    check("t2_stop2", bits[9], 1'b1);
    check("t2_gap12", t2 - t1, 42);
    repeat (3) @(negedge clk);
    check("t2_pops", rp[0], 4);
    check("t2_dones", fdc[0] - base, 3);

    // 3: even and odd parity
    push(1, 8'hA5);
    rx_frame(1, 11, bits, t0, ok);
    check("t3e_ok", ok, 1'b1);
    check("t3e_bits", bits, 16'h054A);
    @(negedge clk);
    check("t3e_done", fd[1], 1'b1);
    check("t3e_len", cyc - t0, 44);
    push(2, 8'hA5);
    rx_frame(2, 11, bits, t0, ok);
    check("t3o_ok", ok, 1'b1);
    check("t3o_bits", bits, 16'h074A);
    @(negedge clk);
    check("t3o_done", fd[2], 1'b1);
    check("t3o_len", cyc - t0, 44);

    // 4: two stop bits, 0x81 twice
    push(3, 8'h81);
    push(3, 8'h81);
    rx_frame(3, 11, bits, t0, ok);
    check("t4_ok0", ok, 1'b1);
    check("t4_bits0", bits, 16'h0702);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx[3] !== 1'b1) break;
      n++;
    end
    check("t4_gap", n, 2);
    rx_frame(3, 11, bits, t1, ok);
    check("t4_ok1", ok, 1'b1);
    check("t4_bits1", bits, 16'h0702);
    check("t4_period", t1 - t0, 46);
    repeat (3) @(negedge clk);
    check("t4_pops", rp[3], 2);

    // 5: idle with empty FIFOs
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      for (int g = 0; g < N; g++)
        if (rd[g] !== 1'b0 || tx[g] !== 1'b1 || busy[g] !== 1'b0) bad++;
    end
    check("t5_idle", bad, 0);

    // 6: reset during data bit 3 of 0x5A
    base = rp[0];
    push(0, 8'h5A);
    push(0, 8'h77);
    for (int i = 0; i < 20 && tx[0] !== 1'b0; i++) @(negedge clk);
    check("t6_start", tx[0], 1'b0);
    repeat (17) @(negedge clk);
    check("t6_busy_pre", busy[0], 1'b1);
    rst = 1'b1;
    #1;
    check("t6_rd_rst", rd[0], 1'b0);
    @(negedge clk);
    check("t6_tx", tx[0], 1'b1);
    check("t6_busy", busy[0], 1'b0);
    rst = 1'b0;
    rx_frame(0, 10, bits, t0, ok);
    check("t6_ok", ok, 1'b1);
    check("t6_word", bits[8:1], 8'h77);
    repeat (60) @(negedge clk);
    check("t6_pops", rp[0] - base, 2);
    check("t6_quiet", tx[0], 1'b1);
    check("t6_idle", busy[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
